// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: walks a 0..31 shift in steps of up to 3 bits per clock.
// Optional rotate-right support is compiled in with the SHIFT_SEQ_ROTR_EN macro.
module shift_seq #(
    parameter int D_WIDTH  = 32,
    parameter int SH_WIDTH = 5,
    parameter int STEP_MAX = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                START,
    input  logic [1:0]          OP,
    input  logic [SH_WIDTH-1:0] SHAMT,
    input  logic [D_WIDTH-1:0]  D_IN,
    output logic                BUSY,
    output logic                DONE,
    output logic [2:0]          BS_AMT,
    output logic [D_WIDTH-1:0]  D_OUT
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    state_t              state_q, state_d;
    logic [D_WIDTH-1:0]  opnd_q, opnd_d;
    logic [SH_WIDTH-1:0] rem_q, rem_d;
    logic [1:0]          op_q, op_d;
    logic [D_WIDTH-1:0]  dout_q, dout_d;
    logic [1:0]          step;
    logic                rotrBypass;

    // Without rotate support an OP=11 request completes immediately with the operand untouched.
`ifdef SHIFT_SEQ_ROTR_EN
    assign rotrBypass = 1'b0;
`else
    assign rotrBypass = (OP == OP_ROTR);
`endif

    assign step = (rem_q >= SH_WIDTH'(STEP_MAX)) ? 2'(STEP_MAX) : rem_q[1:0];

    function automatic logic [D_WIDTH-1:0] stepShift(
        input logic [D_WIDTH-1:0] x,
        input logic [1:0]         op,
        input logic [1:0]         s
    );
        logic [D_WIDTH-1:0] r;
        r = x;
        case (op)
            OP_SLL: r = x << s;
            OP_SRL: r = x >> s;
            OP_SRA: r = $signed(x) >>> s;
`ifdef SHIFT_SEQ_ROTR_EN
            OP_ROTR: begin
                case (s)
                    2'd1:    r = {x[0],   x[D_WIDTH-1:1]};
                    2'd2:    r = {x[1:0], x[D_WIDTH-1:2]};
                    2'd3:    r = {x[2:0], x[D_WIDTH-1:3]};
                    default: r = x;
                endcase
            end
`endif
            default: r = x;
        endcase
        return r;
    endfunction

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            opnd_q  <= '0;
            rem_q   <= '0;
            op_q    <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            opnd_q  <= opnd_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            dout_q  <= dout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        opnd_d  = opnd_q;
        rem_d   = rem_q;
        op_d    = op_q;
        dout_d  = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    opnd_d = D_IN;
                    op_d   = OP;
                    rem_d  = SHAMT;
                    if ((SHAMT == '0) || rotrBypass) begin
                        rem_d   = '0;
                        dout_d  = D_IN;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                opnd_d = stepShift(opnd_q, op_q, step);
                rem_d  = rem_q - SH_WIDTH'(step);
                // Result is captured on the same edge that consumes the last step.
                if (rem_d == '0) begin
                    dout_d  = opnd_d;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSY   = (state_q != ST_IDLE);
        DONE   = (state_q == ST_DONE);
        D_OUT  = dout_q;
        BS_AMT = 3'b000;
        if (state_q == ST_SHIFT) begin
            case (step)
                2'd3:    BS_AMT = 3'b110;
                2'd2:    BS_AMT = 3'b100;
                2'd1:    BS_AMT = 3'b010;
                default: BS_AMT = 3'b000;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Scoreboard bench for shift_seq: directed cases plus random requests against a single-shot shift model.
// Honours SHIFT_SEQ_ROTR_EN the same way as the design.
module tb_shift_seq;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [1:0]  OP;
    logic [4:0]  SHAMT;
    logic [31:0] D_IN;
    logic        BUSY;
    logic        DONE;
    logic [2:0]  BS_AMT;
    logic [31:0] D_OUT;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        int          nShift;
    } exp_t;

    exp_t       sbQ[$];
    logic [2:0] bsQ[$];

    shift_seq #(.D_WIDTH(32), .SH_WIDTH(5), .STEP_MAX(3)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .SHAMT(SHAMT), .D_IN(D_IN),
        .BUSY(BUSY), .DONE(DONE), .BS_AMT(BS_AMT), .D_OUT(D_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event not allowed here at %0t", name, $time);
    endtask

    // Reference: single-shot shift, independent of the stepping
    function automatic logic [31:0] modelResult(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] din);
        logic [63:0] w;
        logic [31:0] r;
        w = {din, din} >> sh;
        case (op)
            2'b00:   r = din << sh;
            2'b01:   r = din >> sh;
            2'b10:   r = $signed(din) >>> sh;
`ifdef SHIFT_SEQ_ROTR_EN
            default: r = w[31:0];
`else
            default: r = din;
`endif
        endcase
        return r;
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic [4:0] sh, input logic [31:0] din);
        exp_t e;
        int   rem;
        int   s;
        int   waited;
        bit   stepped;
        waited = 0;
        @(negedge CLK);
        while (BUSY && waited < 100) begin
            @(negedge CLK);
            waited++;
        end
        if (BUSY) reportFail("idleTimeout");
        stepped = 1'b1;
`ifndef SHIFT_SEQ_ROTR_EN
        if (op == 2'b11) stepped = 1'b0;
`endif
        e.res    = modelResult(op, sh, din);
        e.nShift = 0;
        rem      = stepped ? int'(sh) : 0;
        while (rem > 0) begin
            s = (rem > 3) ? 3 : rem;
            case (s)
                3:       bsQ.push_back(3'b110);
                2:       bsQ.push_back(3'b100);
                default: bsQ.push_back(3'b010);
            endcase
            rem -= s;
            e.nShift++;
        end
        sbQ.push_back(e);
        OP    = op;
        SHAMT = sh;
        D_IN  = din;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        OP    = 2'($urandom_range(0, 3));
        SHAMT = 5'($urandom_range(0, 31));
        D_IN  = $urandom;
    endtask

    // Monitor: every SHIFT cycle pops a step code, every DONE pops a result
    initial begin : monitor
        int          shiftCount;
        logic [31:0] holdVal;
        exp_t        e;
        shiftCount = 0;
        holdVal    = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                shiftCount = 0;
                holdVal    = '0;
            end else if (DONE) begin
                if (sbQ.size() == 0) begin
                    reportFail("unexpectedDone");
                end else begin
                    e = sbQ.pop_front();
                    checkOutput("dOut", D_OUT, e.res);
                    checkOutput("shiftCycles", 32'(shiftCount), 32'(e.nShift));
                    checkOutput("bsAmtInDone", 32'(BS_AMT), 32'd0);
                    holdVal = e.res;
                end
                shiftCount = 0;
            end else if (BUSY) begin
                shiftCount++;
                if (bsQ.size() == 0) reportFail("extraShiftCycle");
                else checkOutput("bsAmt", 32'(BS_AMT), 32'(bsQ.pop_front()));
            end else begin
                checkOutput("dOutHold", D_OUT, holdVal);
                checkOutput("bsAmtIdle", 32'(BS_AMT), 32'd0);
            end
        end
    end

    initial begin : stimulus
        int waited;
        RST   = 1'b1;
        START = 1'b0;
        OP    = 2'b00;
        SHAMT = '0;
        D_IN  = '0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("resetBusy", 32'(BUSY), 32'd0);
        checkOutput("resetDone", 32'(DONE), 32'd0);
        checkOutput("resetBsAmt", 32'(BS_AMT), 32'd0);
        checkOutput("resetDout", D_OUT, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        applyStimulus(2'b10, 5'd31, 32'h8000_0000);
        applyStimulus(2'b01, 5'd4, 32'h8000_0000);
        applyStimulus(2'b00, 5'd0, 32'h0000_0001);

        // A second START while busy must neither queue nor re-sample inputs
        applyStimulus(2'b01, 5'd9, 32'h0000_F000);
        @(negedge CLK);
        START = 1'b1;
        D_IN  = 32'hFFFF_FFFF;
        OP    = 2'b00;
        SHAMT = 5'd1;
        repeat (4) @(posedge CLK);
        #1;
        START = 1'b0;

        // Asynchronous reset in the middle of the third step
        applyStimulus(2'b10, 5'd20, 32'h8765_4321);
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        sbQ.delete();
        bsQ.delete();
        #1;
        checkOutput("midResetBusy", 32'(BUSY), 32'd0);
        checkOutput("midResetDone", 32'(DONE), 32'd0);
        checkOutput("midResetBsAmt", 32'(BS_AMT), 32'd0);
        checkOutput("midResetDout", D_OUT, 32'd0);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        applyStimulus(2'b10, 5'd20, 32'h8765_4321);

        applyStimulus(2'b11, 5'd1, 32'h0000_0001);
        applyStimulus(2'b11, 5'd31, 32'h1234_5678);

        for (int i = 0; i < 40; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom);
        end

        waited = 0;
        while ((sbQ.size() != 0 || BUSY) && waited < 200) begin
            @(negedge CLK);
            waited++;
        end
        checkOutput("pendingResults", 32'(sbQ.size()), 32'd0);
        checkOutput("pendingSteps", 32'(bsQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
